// File: rtl/exp_accel_mem_pkg.sv
// Shared constants and parameter helpers for the exponent-accelerator on-chip RAM.
package exp_accel_mem_pkg;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 2;

    // Number of 8-bit byte lanes in a data word.
    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

    // Legal configuration: whole bytes per word and a supported read latency.
    function automatic bit params_ok(input int data_w, input int read_latency);
        return (data_w > 0) && ((data_w % 8) == 0) &&
               (read_latency >= MIN_READ_LATENCY) && (read_latency <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/exp_accel_tdp_ram_core.sv
// True-dual-port byte-enabled RAM with registered reads returning pre-write data.
module exp_accel_tdp_ram_core
    import exp_accel_mem_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 13,
    parameter string INIT_FILE = "",
    localparam int   LANES     = byte_lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_rd,
    input  logic [LANES-1:0]  a_we,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_q,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_rd,
    input  logic [LANES-1:0]  b_we,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_q
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Power-up contents start at zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    // Byte-lane writes; port a is applied last so it wins any lane both ports touch.
    always_ff @(posedge clk) begin
        if (ce) begin
            for (int i = 0; i < LANES; i++) begin
                if (b_we[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
                if (a_we[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
        end
    end

    // Registered reads; nonblocking update of mem means a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (srst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (ce) begin
            if (a_rd) a_q <= mem[a_addr];
            if (b_rd) b_q <= mem[b_addr];
        end
    end

endmodule

// File: rtl/exp_accel_dp_onchip_ram.sv
// Dual-port Avalon-MM on-chip RAM: s1 for the CPU fabric, s2 for the accelerator.
module exp_accel_dp_onchip_ram
    import exp_accel_mem_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    ADDR_W       = 13,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "",
    localparam int   LANES        = byte_lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,
    input  logic              clken,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_chipselect,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [LANES-1:0]  s1_byteenable,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    input  logic [ADDR_W-1:0] s2_address,
    input  logic              s2_chipselect,
    input  logic              s2_read,
    input  logic              s2_write,
    input  logic [LANES-1:0]  s2_byteenable,
    input  logic [DATA_W-1:0] s2_writedata,
    output logic [DATA_W-1:0] s2_readdata,
    output logic              s2_readdatavalid,
    output logic              s2_collision
);

    if (!params_ok(DATA_W, READ_LATENCY)) begin : g_bad_params
        $error("exp_accel_dp_onchip_ram: DATA_W must be a multiple of 8 and READ_LATENCY 1 or 2");
    end

    logic              en;
    logic              s1_wr_issue;
    logic              s2_wr_issue;
    logic              collide;
    logic [LANES-1:0]  s1_we;
    logic [LANES-1:0]  s2_we;
    logic [1:0]        rd_issue;
    logic [1:0]        rdv;
    logic [DATA_W-1:0] core_q [2];
    logic [DATA_W-1:0] rdata  [2];
    logic              collision_reg;

    // A write strobe takes priority over a simultaneous read strobe on the same port.
    assign en          = clken & ~reset_req;
    assign s1_wr_issue = en & s1_chipselect & s1_write;
    assign s2_wr_issue = en & s2_chipselect & s2_write;
    assign rd_issue[0] = en & s1_chipselect & s1_read & ~s1_write;
    assign rd_issue[1] = en & s2_chipselect & s2_read & ~s2_write;

    // Same-address double write: s1 lands whole, s2 is dropped entirely.
    assign collide = s1_wr_issue & s2_wr_issue & (s1_address == s2_address);
    assign s1_we   = s1_wr_issue ? s1_byteenable : '0;
    assign s2_we   = (s2_wr_issue && !collide) ? s2_byteenable : '0;

    exp_accel_tdp_ram_core #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_core (
        .clk     (clk),
        .srst    (reset),
        .ce      (en),
        .a_addr  (s1_address),
        .a_rd    (rd_issue[0]),
        .a_we    (s1_we),
        .a_wdata (s1_writedata),
        .a_q     (core_q[0]),
        .b_addr  (s2_address),
        .b_rd    (rd_issue[1]),
        .b_we    (s2_we),
        .b_wdata (s2_writedata),
        .b_q     (core_q[1])
    );

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_port
        logic [READ_LATENCY-1:0] vld_reg;

        // Read-valid shift register; frozen while disabled so no valid is lost or repeated.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_reg <= '0;
            end else if (en) begin
                vld_reg <= READ_LATENCY'({vld_reg, rd_issue[gi]});
            end
        end

        // A held valid is only presented on an enabled cycle, and never during reset.
        assign rdv[gi] = vld_reg[READ_LATENCY-1] & en & ~reset;

        if (READ_LATENCY == 1) begin : g_direct
            assign rdata[gi] = core_q[gi];
        end else begin : g_outreg
            logic [DATA_W-1:0] rdata_reg;

            // Extra output stage captures RAM data only when a read is moving through.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_reg <= '0;
                end else if (en && vld_reg[0]) begin
                    rdata_reg <= core_q[gi];
                end
            end

            assign rdata[gi] = rdata_reg;
        end
    end

    // Sticky flag recording that an s2 write was discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            collision_reg <= 1'b0;
        end else if (collide) begin
            collision_reg <= 1'b1;
        end
    end

    assign s1_readdata      = rdata[0];
    assign s2_readdata      = rdata[1];
    assign s1_readdatavalid = rdv[0];
    assign s2_readdatavalid = rdv[1];
    assign s2_collision     = collision_reg;

endmodule

// File: tb/tb_exp_accel_dp_onchip_ram.sv
// Directed bench driving two configurations in lockstep:
// dut_a = 32-bit / 13-bit address / latency 1, dut_b = 64-bit / 10-bit address / latency 2.
// dut_b sees every write word and byteenable duplicated in both halves.
module tb_exp_accel_dp_onchip_ram;

    logic        clk = 1'b0;
    logic        reset, reset_req, clken;
    logic [12:0] s1_address, s2_address;
    logic        s1_chipselect, s1_read, s1_write;
    logic        s2_chipselect, s2_read, s2_write;
    logic [7:0]  s1_byteenable, s2_byteenable;
    logic [63:0] s1_writedata, s2_writedata;

    logic [31:0] a_s1_readdata, a_s2_readdata;
    logic        a_s1_rdv, a_s2_rdv, a_col;
    logic [63:0] b_s1_readdata, b_s2_readdata;
    logic        b_s1_rdv, b_s2_rdv, b_col;

    int checks = 0;
    int errors = 0;

    int a_vtab [9] = '{0, 1, 0, 0, 1, 1, 1, 0, 0};
    int a_itab [9] = '{0, 0, 0, 0, 1, 2, 3, 0, 0};
    int b_vtab [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int b_itab [9] = '{0, 0, 0, 0, 0, 1, 2, 3, 0};
    int addr_tab [6] = '{0, 1, 2, 2, 2, 3};

    always #5 clk = ~clk;

    exp_accel_dp_onchip_ram #(.DATA_W(32), .ADDR_W(13), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable[3:0]), .s1_writedata(s1_writedata[31:0]),
        .s1_readdata(a_s1_readdata), .s1_readdatavalid(a_s1_rdv),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable[3:0]), .s2_writedata(s2_writedata[31:0]),
        .s2_readdata(a_s2_readdata), .s2_readdatavalid(a_s2_rdv), .s2_collision(a_col)
    );

    exp_accel_dp_onchip_ram #(.DATA_W(64), .ADDR_W(10), .READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_address(s1_address[9:0]), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(b_s1_readdata), .s1_readdatavalid(b_s1_rdv),
        .s2_address(s2_address[9:0]), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(b_s2_readdata), .s2_readdatavalid(b_s2_rdv), .s2_collision(b_col)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic a_rdv(input bit p);
        return p ? a_s2_rdv : a_s1_rdv;
    endfunction

    function automatic logic b_rdv(input bit p);
        return p ? b_s2_rdv : b_s1_rdv;
    endfunction

    function automatic logic [31:0] a_rdata(input bit p);
        return p ? a_s2_readdata : a_s1_readdata;
    endfunction

    function automatic logic [63:0] b_rdata(input bit p);
        return p ? b_s2_readdata : b_s1_readdata;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
        s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
        s1_byteenable = '0;   s2_byteenable = '0;
    endtask

    task automatic drive_wr(input bit port, input logic [12:0] addr, input logic [31:0] d,
                            input logic [3:0] be);
        if (!port) begin
            s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = addr;
            s1_writedata = {d, d}; s1_byteenable = {be, be};
        end else begin
            s2_chipselect = 1'b1; s2_write = 1'b1; s2_address = addr;
            s2_writedata = {d, d}; s2_byteenable = {be, be};
        end
    endtask

    task automatic drive_rd(input bit port, input logic [12:0] addr);
        if (!port) begin
            s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = addr;
        end else begin
            s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = addr;
        end
    endtask

    task automatic wr(input bit port, input logic [12:0] addr, input logic [31:0] d,
                      input logic [3:0] be);
        drive_wr(port, addr, d, be);
        tick();
        idle();
    endtask

    // Checks the response to a read whose issuing edge has just passed.
    task automatic rd_expect(input string tag, input bit port, input logic [31:0] exp);
        check_val({tag, "_a_valid"}, {63'd0, a_rdv(port)}, 64'd1);
        check_val({tag, "_a_data"}, {32'd0, a_rdata(port)}, {32'd0, exp});
        check_val({tag, "_b_early"}, {63'd0, b_rdv(port)}, 64'd0);
        tick();
        check_val({tag, "_a_single"}, {63'd0, a_rdv(port)}, 64'd0);
        check_val({tag, "_a_hold"}, {32'd0, a_rdata(port)}, {32'd0, exp});
        check_val({tag, "_b_valid"}, {63'd0, b_rdv(port)}, 64'd1);
        check_val({tag, "_b_data"}, b_rdata(port), {exp, exp});
        tick();
        check_val({tag, "_b_single"}, {63'd0, b_rdv(port)}, 64'd0);
    endtask

    task automatic rd_chk(input string tag, input bit port, input logic [12:0] addr,
                          input logic [31:0] exp);
        drive_rd(port, addr);
        tick();
        idle();
        rd_expect(tag, port, exp);
    endtask

    initial begin
        int a_cnt;
        int b_cnt;
        reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
        s1_address = '0; s2_address = '0; s1_writedata = '0; s2_writedata = '0;
        idle();
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check_val("rst_a_rdata", {a_s1_readdata, a_s2_readdata}, 64'd0);
        check_val("rst_b_rdata1", b_s1_readdata, 64'd0);
        check_val("rst_b_rdata2", b_s2_readdata, 64'd0);
        check_val("rst_valids", {60'd0, a_s1_rdv, a_s2_rdv, b_s1_rdv, b_s2_rdv}, 64'd0);
        check_val("rst_collision", {62'd0, a_col, b_col}, 64'd0);

        // Cross-port write then read
        wr(0, 13'h010, 32'hDEADBEEF, 4'hF);
        rd_chk("t1", 1, 13'h010, 32'hDEADBEEF);

        // Byte-lane merge and zero-byteenable no-op
        wr(0, 13'd5, 32'h11223344, 4'hF);
        wr(0, 13'd5, 32'hAABBCCDD, 4'b0100);
        rd_chk("t2", 1, 13'd5, 32'h11BB3344);
        wr(1, 13'd5, 32'hFFFFFFFF, 4'h0);
        rd_chk("t2_be0", 0, 13'd5, 32'h11BB3344);

        // Simultaneous writes to different addresses both land
        drive_wr(0, 13'h020, 32'h01010101, 4'hF);
        drive_wr(1, 13'h021, 32'h02020202, 4'hF);
        tick();
        idle();
        check_val("t3_nocol", {62'd0, a_col, b_col}, 64'd0);
        rd_chk("t3_p1", 0, 13'h020, 32'h01010101);
        rd_chk("t3_p2", 1, 13'h021, 32'h02020202);

        // Same-address collision: s1 wins, sticky flag
        drive_wr(0, 13'h1FF, 32'hAAAA0000, 4'hF);
        drive_wr(1, 13'h1FF, 32'h0000BBBB, 4'hF);
        tick();
        idle();
        check_val("t3_col_set", {62'd0, a_col, b_col}, 64'd3);
        rd_chk("t3_col", 1, 13'h1FF, 32'hAAAA0000);
        repeat (3) tick();
        check_val("t3_col_sticky", {62'd0, a_col, b_col}, 64'd3);

        // Read burst with clken dropped for two cycles
        for (int i = 0; i < 4; i++) wr(0, 13'h040 + 13'(i), 32'hC0DE0000 + 32'(i), 4'hF);
        a_cnt = 0;
        b_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            idle();
            clken = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            if (k < 6) drive_rd(1, 13'h040 + 13'(addr_tab[k]));
            #1;
            check_val($sformatf("t4_a_v%0d", k), {63'd0, a_s2_rdv}, 64'(a_vtab[k]));
            check_val($sformatf("t4_b_v%0d", k), {63'd0, b_s2_rdv}, 64'(b_vtab[k]));
            if (a_s2_rdv) begin
                a_cnt++;
                check_val($sformatf("t4_a_d%0d", k), {32'd0, a_s2_readdata},
                          {32'd0, 32'hC0DE0000 + 32'(a_itab[k])});
            end
            if (b_s2_rdv) begin
                b_cnt++;
                check_val($sformatf("t4_b_d%0d", k), b_s2_readdata,
                          {2{32'hC0DE0000 + 32'(b_itab[k])}});
            end
            tick();
        end
        idle();
        clken = 1'b1;
        check_val("t4_a_count", 64'(a_cnt), 64'd4);
        check_val("t4_b_count", 64'(b_cnt), 64'd4);

        // Reset while a read is in flight
        drive_rd(1, 13'h010);
        tick();
        idle();
        reset = 1'b1;
        #1;
        check_val("t5_rst_valid", {62'd0, a_s2_rdv, b_s2_rdv}, 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check_val("t5_after_valid", {62'd0, a_s2_rdv, b_s2_rdv}, 64'd0);
        check_val("t5_a_rdata", {32'd0, a_s2_readdata}, 64'd0);
        check_val("t5_b_rdata", b_s2_readdata, 64'd0);
        check_val("t5_col_clr", {62'd0, a_col, b_col}, 64'd0);
        tick();
        check_val("t5_flushed", {62'd0, a_s2_rdv, b_s2_rdv}, 64'd0);
        rd_chk("t5_kept", 1, 13'h010, 32'hDEADBEEF);

        // Cross-port read during write returns old data
        drive_wr(0, 13'h010, 32'h55AA55AA, 4'hF);
        drive_rd(1, 13'h010);
        tick();
        idle();
        rd_expect("xp_old", 1, 32'hDEADBEEF);
        rd_chk("xp_new", 1, 13'h010, 32'h55AA55AA);

        // Read and write together on one port: write only, no valid
        drive_wr(1, 13'h030, 32'h77777777, 4'hF);
        s2_read = 1'b1;
        tick();
        idle();
        check_val("rw_a_novalid", {63'd0, a_s2_rdv}, 64'd0);
        tick();
        check_val("rw_b_novalid", {63'd0, b_s2_rdv}, 64'd0);
        rd_chk("rw_data", 1, 13'h030, 32'h77777777);

        // reset_req suppresses writes and reads
        wr(0, 13'd3, 32'h0BADF00D, 4'hF);
        reset_req = 1'b1;
        drive_wr(0, 13'd3, 32'h12345678, 4'hF);
        drive_rd(1, 13'h010);
        tick();
        idle();
        reset_req = 1'b0;
        #1;
        check_val("t6_a_noread", {63'd0, a_s2_rdv}, 64'd0);
        tick();
        check_val("t6_b_noread", {63'd0, b_s2_rdv}, 64'd0);
        rd_chk("t6", 0, 13'd3, 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
